digit_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit display. Sits directly upstream of the 2-to-4 active-low digit decoder: it produces the 2-bit digit select that the decoder turns into one-hot-low digit enables, and in the same cycle it presents the matching hex nibble, decimal point and blank flag to the segment path. A frame-synchronous shadow register keeps digits from tearing when the displayed value changes.

---
 rtl/disp_pkg.sv | 39 +++
 rtl/digit_scan_ctrl_prescaler.sv | 38 +++
 rtl/digit_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_digit_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display definitions: digit geometry, scan FSM states and the
// helpers used to pick a nibble and decide leading-zero blanking.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

  typedef enum logic {
    ST_OFF  = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] dp_mask;
  } disp_word_t;

  function automatic logic [NIBBLE_W-1:0] nibble_at(input logic [VALUE_W-1:0] v,
                                                    input logic [SEL_W-1:0]   k);
    return v[k*NIBBLE_W +: NIBBLE_W];
  endfunction

  // Digit k is a leading zero when it and every more-significant nibble is zero;
  // digit 0 always shows.
  function automatic logic lz_hidden(input logic [VALUE_W-1:0] v,
                                     input logic [SEL_W-1:0]   k);
    logic hidden;
    hidden = (k != '0);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (i >= 32'(k) && v[i*NIBBLE_W +: NIBBLE_W] != '0) begin
        hidden = 1'b0;
      end
    end
    return hidden;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_prescaler.sv
// Slot divider: counts 0..CLK_DIV-1 while running and flags the terminal count.
module scan_prescaler #(
  parameter  int unsigned CLK_DIV = 50000,
  localparam int unsigned CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  output logic             tc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc    = run && !clr && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit scan controller: drives the digit select plus the matching nibble,
// decimal point and blank flag, with frame-synchronous update of the shown value.
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  lz_blank,
  output logic [SEL_W-1:0]      sel,
  output logic [NIBBLE_W-1:0]   digit,
  output logic                  dp,
  output logic                  blank,
  output logic                  tick
);

  localparam int unsigned PCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  scan_state_e          state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NIBBLE_W-1:0]  digit_q, digit_d;
  logic                 dp_q, dp_d;
  logic                 blank_q, blank_d;
  logic                 tick_q, tick_d;
  disp_word_t           active_q, active_d;
  disp_word_t           pending_q, pending_d;
  logic                 pend_v_q, pend_v_d;

  disp_word_t           incoming;
  logic                 run, clr, tc;
  logic                 frame_end, transfer;
  logic [PCNT_W-1:0]    pcnt;

  assign incoming = {value, dp_mask};
  assign run      = (state_q == ST_SCAN) && en;
  assign clr      = !run;

  scan_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .run  (run),
    .tc   (tc),
    .count(pcnt)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    digit_d   = digit_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    tick_d    = 1'b0;
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;

    frame_end = tc && (sel_q == SEL_W'(NUM_DIGITS - 1));
    transfer  = en && ((state_q == ST_OFF) || frame_end);

    // A load landing on a transfer edge bypasses pending entirely.
    if (transfer && load) begin
      active_d = incoming;
      pend_v_d = 1'b0;
    end else if (transfer) begin
      if (pend_v_q) begin
        active_d = pending_q;
      end
      pend_v_d = 1'b0;
    end else if (load) begin
      pending_d = incoming;
      pend_v_d  = 1'b1;
    end

    if (!en) begin
      state_d = ST_OFF;
      sel_d   = '0;
      blank_d = 1'b1;
    end else begin
      state_d = ST_SCAN;
      if (state_q == ST_OFF) begin
        sel_d = '0;
      end else if (tc) begin
        sel_d = sel_q + 1'b1;
      end
      tick_d = tc;
      // Slot outputs come from next-state sel/active so they register together.
      digit_d = nibble_at(active_d.value, sel_d);
      dp_d    = active_d.dp_mask[sel_d];
      blank_d = lz_blank && lz_hidden(active_d.value, sel_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      sel_q     <= '0;
      digit_q   <= '0;
      dp_q      <= 1'b0;
      blank_q   <= 1'b1;
      tick_q    <= 1'b0;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      digit_q   <= digit_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      tick_q    <= tick_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
    end
  end

  assign sel   = sel_q;
  assign digit = digit_q;
  assign dp    = dp_q;
  assign blank = blank_q;
  assign tick  = tick_q;

  off_is_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_OFF) |-> (pcnt == '0 && !tick_q));

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Randomized and directed bench for digit_scan_ctrl against a cycle-count model.
module tb_digit_scan_ctrl;

  localparam int D     = 4;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst, en, load, lz_blank;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [1:0]  sel;
  logic [3:0]  digit;
  logic        dp, blank, tick;

  int total = 0;
  int bad   = 0;

  // reference state: time since enable, displayed word, pending word queue
  bit          m_on;
  int          m_n;
  logic [15:0] m_val;
  logic [3:0]  m_dpm;
  logic [19:0] pend_q[$];
  logic [1:0]  e_sel;
  logic [3:0]  e_digit;
  logic        e_dp, e_blank, e_tick;

  logic g_en, g_lz;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .value   (value),
    .dp_mask (dp_mask),
    .lz_blank(lz_blank),
    .sel     (sel),
    .digit   (digit),
    .dp      (dp),
    .blank   (blank),
    .tick    (tick)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    bit was_on, boundary;
    int s;
    logic [19:0] w;
    if (rst) begin
      m_on = 0; m_n = 0; m_val = '0; m_dpm = '0; pend_q.delete();
      e_sel = 0; e_digit = 0; e_dp = 0; e_blank = 1; e_tick = 0;
    end else if (!en) begin
      if (load) begin pend_q.delete(); pend_q.push_back({value, dp_mask}); end
      m_on = 0; m_n = 0;
      e_sel = 0; e_blank = 1; e_tick = 0;
    end else begin
      was_on   = m_on;
      boundary = !was_on || (m_n % FRAME == FRAME - 1);
      m_n      = was_on ? m_n + 1 : 0;
      m_on     = 1;
      if (boundary) begin
        if (load) begin
          m_val = value; m_dpm = dp_mask; pend_q.delete();
        end else if (pend_q.size() > 0) begin
          w = pend_q.pop_back(); pend_q.delete();
          m_val = w[19:4]; m_dpm = w[3:0];
        end
      end else if (load) begin
        pend_q.delete(); pend_q.push_back({value, dp_mask});
      end
      s       = (m_n / D) % 4;
      e_sel   = 2'(s);
      e_tick  = was_on && (m_n % D == 0);
      e_digit = 4'((m_val >> (4 * s)) & 16'hF);
      e_dp    = m_dpm[s];
      e_blank = lz_blank && (s != 0) && ((m_val >> (4 * s)) == 16'h0);
    end
  endtask

  task automatic step(input logic r_i, input logic e_i, input logic l_i,
                      input logic [15:0] v_i, input logic [3:0] d_i, input logic lz_i);
    @(negedge clk);
    rst = r_i; en = e_i; load = l_i; value = v_i; dp_mask = d_i; lz_blank = lz_i;
    model_step();
    @(posedge clk);
    #1;
    chk("sel",   {14'b0, sel},   {14'b0, e_sel});
    chk("digit", {12'b0, digit}, {12'b0, e_digit});
    chk("dp",    {15'b0, dp},    {15'b0, e_dp});
    chk("blank", {15'b0, blank}, {15'b0, e_blank});
    chk("tick",  {15'b0, tick},  {15'b0, e_tick});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, g_en, 1'b0, 16'h0, 4'h0, g_lz);
  endtask

  // Advance until the next edge lands at frame position `phase` (pre-edge count).
  task automatic idle_until(input int phase);
    int guard = 0;
    while (!(m_on && (m_n % FRAME == phase)) && guard < 4 * FRAME) begin
      step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, g_lz);
      guard++;
    end
    chk("phase_reach", 16'(guard < 4 * FRAME), 16'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; en = 0; load = 0; value = 0; dp_mask = 0; lz_blank = 0;
    g_en = 1; g_lz = 0;

    step(1, 0, 0, 16'h0, 4'h0, 0);
    step(1, 0, 0, 16'h0, 4'h0, 0);

    // load while off, then scan: digits 4,3,2,1
    step(0, 0, 1, 16'h1234, 4'b0101, 0);
    step(0, 0, 0, 16'h0, 4'h0, 0);
    idle(20);

    // mid-frame load shows only after the wrap
    idle_until(4);
    step(0, 1, 1, 16'hABCD, 4'b1010, 0);
    idle(2 * FRAME);

    // boundary bypass overrides an older pending value
    idle_until(6);
    step(0, 1, 1, 16'h9999, 4'b1111, 0);
    idle_until(FRAME - 1);
    step(0, 1, 1, 16'h5555, 4'b0001, 0);
    idle(2 * FRAME);

    // leading-zero blanking
    g_lz = 1;
    step(0, 1, 1, 16'h0070, 4'b1100, 1);
    idle(2 * FRAME + 4);
    step(0, 1, 1, 16'h0000, 4'b0110, 1);
    idle(2 * FRAME + 4);
    g_lz = 0;

    // disable at sel 2 then re-enable
    idle_until(2 * D + 1);
    step(0, 0, 0, 16'h0, 4'h0, 0);
    step(0, 0, 0, 16'h0, 4'h0, 0);
    idle(D + 2);

    // reset mid-frame discards pending
    idle_until(3);
    step(0, 1, 1, 16'h1111, 4'b1111, 0);
    step(1, 1, 0, 16'h0, 4'h0, 0);
    step(0, 0, 0, 16'h0, 4'h0, 0);
    idle(FRAME + 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 2) == 0) v[4*k +: 4] = 4'h0;
      if ($urandom_range(0, 99) == 0) g_lz = ~g_lz;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 39) != 0,
           $urandom_range(0, 9) == 0,
           v, 4'($urandom), g_lz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
